serv_rf_dbg_arb: RTL and testbench

Register-file RAM port arbiter between the SERV register-file interface and the debug module. It sits between `serv_rf_ram_if` and `serv_rf_ram` and gives the CPU unconditional priority. While the core is halted, it serializes 32-bit debug GPR/CSR-slot reads and writes into `RF_WIDTH`-bit RAM beats. This gives the debugger abstract register access without a second RAM port.

---
 rtl/serv_rf_dbg_arb.sv | 148 ++++++++++++++
 tb/tb_serv_rf_dbg_arb.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_rf_dbg_arb.sv
// serv_rf_dbg_arb: arbitrates the SERV RF RAM port between the core (priority)
// and debug 32-bit register accesses, which are split into RF_WIDTH-bit beats.
// Ports:
//   i_cpu_*  : RAM requests from serv_rf_ram_if
//   o_ram_*  : RAM port to serv_rf_ram
//   i_ram_rdata : RAM read data (one cycle after ren)
//   o_cpu_rdata : RAM read data returned to the core
//   i_dbg_*  : debug request (level, held until ack)
//   o_dbg_*  : debug ack/err/rdata/busy
module serv_rf_dbg_arb #(
  parameter int RF_WIDTH = 8,
  parameter int RF_L2D   = 8,
  parameter int NREGS    = 36
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic [RF_L2D-1:0]   i_cpu_waddr,
  input  logic [RF_WIDTH-1:0] i_cpu_wdata,
  input  logic                i_cpu_wen,
  input  logic [RF_L2D-1:0]   i_cpu_raddr,
  input  logic                i_cpu_ren,
  output logic [RF_WIDTH-1:0] o_cpu_rdata,
  output logic [RF_L2D-1:0]   o_ram_waddr,
  output logic [RF_WIDTH-1:0] o_ram_wdata,
  output logic                o_ram_wen,
  output logic [RF_L2D-1:0]   o_ram_raddr,
  output logic                o_ram_ren,
  input  logic [RF_WIDTH-1:0] i_ram_rdata,
  input  logic                i_dbg_halted,
  input  logic                i_dbg_req,
  input  logic                i_dbg_we,
  input  logic [5:0]          i_dbg_regno,
  input  logic [31:0]         i_dbg_wdata,
  output logic                o_dbg_ack,
  output logic                o_dbg_err,
  output logic [31:0]         o_dbg_rdata,
  output logic                o_dbg_busy
);

  localparam int BEATS = 32 / RF_WIDTH;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE, CHECK, XFER, DRAIN, ACK
  } state_t;

  state_t        state;
  logic          we_q;
  logic [5:0]    regno_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] beat;
  logic          cap_q;
  logic [CW-1:0] cap_beat;
  logic          err_q;
  logic [31:0]   rdata_q;

  logic                cpu_use;
  logic                dbg_issue;
  logic [RF_L2D-1:0]   dbg_addr;
  logic [RF_WIDTH-1:0] dbg_wdata;

  assign cpu_use = i_cpu_ren | i_cpu_wen;

  // Halt is checked combinationally so no beat leaks out once it drops.
  assign dbg_issue = (state == XFER) & i_dbg_halted & ~cpu_use;

  assign dbg_addr =
    RF_L2D'(32'(regno_q) * BEATS + 32'(beat));
  assign dbg_wdata =
    wdata_q[beat*RF_WIDTH +: RF_WIDTH];

  assign o_ram_waddr = dbg_issue ? dbg_addr : i_cpu_waddr;
  assign o_ram_wdata = dbg_issue ? dbg_wdata : i_cpu_wdata;
  assign o_ram_wen   = dbg_issue ? we_q : i_cpu_wen;
  assign o_ram_raddr = dbg_issue ? dbg_addr : i_cpu_raddr;
  assign o_ram_ren   = dbg_issue ? ~we_q : i_cpu_ren;
  assign o_cpu_rdata = i_ram_rdata;

  assign o_dbg_ack   = (state == ACK);
  assign o_dbg_busy  = (state != IDLE);
  assign o_dbg_err   = err_q;
  assign o_dbg_rdata = rdata_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      regno_q  <= '0;
      wdata_q  <= '0;
      beat     <= '0;
      cap_q    <= 1'b0;
      cap_beat <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      // Only capture data that answers a debug read beat.
      cap_q    <= dbg_issue & ~we_q;
      cap_beat <= beat;
      if (cap_q)
        rdata_q[cap_beat*RF_WIDTH +: RF_WIDTH] <= i_ram_rdata;

      case (state)
        IDLE: begin
          if (i_dbg_req) begin
            we_q    <= i_dbg_we;
            regno_q <= i_dbg_regno;
            wdata_q <= i_dbg_wdata;
            beat    <= '0;
            err_q   <= 1'b0;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (32'(regno_q) >= NREGS || !i_dbg_halted) begin
            err_q <= 1'b1;
            state <= ACK;
          end else if (regno_q == 6'd0) begin
            if (!we_q)
              rdata_q <= '0;
            state <= ACK;
          end else begin
            state <= XFER;
          end
        end
        XFER: begin
          if (!i_dbg_halted) begin
            err_q <= 1'b1;
            state <= ACK;
          end else if (dbg_issue) begin
            if (beat == LAST)
              state <= we_q ? ACK : DRAIN;
            else
              beat <= beat + 1'b1;
          end
        end
        DRAIN: begin
          if (!i_dbg_halted)
            err_q <= 1'b1;
          state <= ACK;
        end
        ACK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serv_rf_dbg_arb.sv
// tb_serv_rf_dbg_arb: directed self-checking bench for serv_rf_dbg_arb
// with a behavioural 256x8 RAM behind the arbiter.
module tb_serv_rf_dbg_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cpu_waddr, cpu_wdata, cpu_raddr;
  logic       cpu_wen, cpu_ren;
  logic [7:0] cpu_rdata;
  logic [7:0] ram_waddr, ram_wdata, ram_raddr;
  logic       ram_wen, ram_ren;
  logic [7:0] ram_rdata;
  logic       halted, dbg_req, dbg_we;
  logic [5:0] dbg_regno;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic       dbg_ack, dbg_err, dbg_busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  serv_rf_dbg_arb #(.RF_WIDTH(8), .RF_L2D(8), .NREGS(36)) dut (
    .clk(clk), .i_rst_n(rst_n),
    .i_cpu_waddr(cpu_waddr), .i_cpu_wdata(cpu_wdata),
    .i_cpu_wen(cpu_wen), .i_cpu_raddr(cpu_raddr),
    .i_cpu_ren(cpu_ren), .o_cpu_rdata(cpu_rdata),
    .o_ram_waddr(ram_waddr), .o_ram_wdata(ram_wdata),
    .o_ram_wen(ram_wen), .o_ram_raddr(ram_raddr),
    .o_ram_ren(ram_ren), .i_ram_rdata(ram_rdata),
    .i_dbg_halted(halted), .i_dbg_req(dbg_req),
    .i_dbg_we(dbg_we), .i_dbg_regno(dbg_regno),
    .i_dbg_wdata(dbg_wdata), .o_dbg_ack(dbg_ack),
    .o_dbg_err(dbg_err), .o_dbg_rdata(dbg_rdata),
    .o_dbg_busy(dbg_busy)
  );

  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    if (ram_ren) ram_rdata <= mem[ram_raddr];
  end

  int cyc, ack_cyc, n_acc;
  logic ack_err;
  int cr_from = 0;
  int cr_to = -1;
  int halt_drop = 0;
  logic       acc_w [16];
  logic [7:0] acc_addr [16];
  logic [7:0] acc_dat [16];
  int         acc_cyc [16];

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    cpu_wen = 1'b1; cpu_waddr = a; cpu_wdata = d;
    @(posedge clk); #1;
    cpu_wen = 1'b0;
  endtask

  task automatic do_access(input logic we, input logic [5:0] rn,
                           input logic [31:0] wd);
    n_acc = 0; ack_cyc = 0; cyc = 0; ack_err = 1'b0;
    dbg_we = we; dbg_regno = rn; dbg_wdata = wd; dbg_req = 1'b1;
    for (int i = 0; i < 30 && ack_cyc == 0; i++) begin
      @(posedge clk); cyc++;
      #1;
      cpu_ren = (cyc >= cr_from && cyc <= cr_to);
      cpu_raddr = 8'd200;
      if (halt_drop != 0 && cyc >= halt_drop) halted = 1'b0;
      #1;
      if (ram_ren && n_acc < 16) begin
        acc_w[n_acc] = 1'b0; acc_addr[n_acc] = ram_raddr;
        acc_dat[n_acc] = 8'd0; acc_cyc[n_acc] = cyc; n_acc++;
      end
      if (ram_wen && n_acc < 16) begin
        acc_w[n_acc] = 1'b1; acc_addr[n_acc] = ram_waddr;
        acc_dat[n_acc] = ram_wdata; acc_cyc[n_acc] = cyc; n_acc++;
      end
      if (dbg_ack) begin ack_cyc = cyc; ack_err = dbg_err; end
    end
    dbg_req = 1'b0; cpu_ren = 1'b0;
    total++;
    if (ack_cyc == 0) begin
      bad++; $display("FAIL timeout: no ack within 30 cycles");
    end
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({dbg_ack, dbg_busy, dbg_err} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got %b want 000",
                      {dbg_ack, dbg_busy, dbg_err});
    end
    total++;
    if (dbg_rdata !== 32'h0) begin
      bad++; $display("FAIL reset_rdata: got %h want 0", dbg_rdata);
    end
    rst_n = 1'b1;
    cpu_ren = 1'b1; cpu_raddr = 8'd9;
    #1;
    total++;
    if (ram_ren !== 1'b1 || ram_raddr !== 8'd9 || ram_wen !== 1'b0) begin
      bad++; $display("FAIL reset_passthru: ren=%b raddr=%0d wen=%b want 1 9 0",
                      ram_ren, ram_raddr, ram_wen);
    end
    cpu_ren = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic test_read_x5();
    cpu_write(8'd20, 8'hD4); cpu_write(8'd21, 8'hC3);
    cpu_write(8'd22, 8'hB2); cpu_write(8'd23, 8'hA1);
    do_access(1'b0, 6'd5, 32'h0);
    total++;
    if (ack_cyc != 7 || ack_err !== 1'b0) begin
      bad++; $display("FAIL rd5_ack: cyc=%0d err=%b want 7 0", ack_cyc, ack_err);
    end
    total++;
    if (dbg_rdata !== 32'hA1B2C3D4) begin
      bad++; $display("FAIL rd5_data: got %h want a1b2c3d4", dbg_rdata);
    end
    total++;
    if (n_acc != 4) begin
      bad++; $display("FAIL rd5_nacc: got %0d want 4", n_acc);
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (acc_w[k] !== 1'b0 || acc_addr[k] !== 8'(20 + k) ||
            acc_cyc[k] != 2 + k) begin
          bad++; $display("FAIL rd5_beat%0d: w=%b addr=%0d cyc=%0d want 0 %0d %0d",
                          k, acc_w[k], acc_addr[k], acc_cyc[k], 20 + k, 2 + k);
        end
      end
    end
  endtask

  task automatic test_write_x31();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h78; exp_d[1] = 8'h56; exp_d[2] = 8'h34; exp_d[3] = 8'h12;
    do_access(1'b1, 6'd31, 32'h12345678);
    total++;
    if (ack_cyc != 6 || ack_err !== 1'b0) begin
      bad++; $display("FAIL wr31_ack: cyc=%0d err=%b want 6 0", ack_cyc, ack_err);
    end
    total++;
    if (n_acc != 4) begin
      bad++; $display("FAIL wr31_nacc: got %0d want 4", n_acc);
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (acc_w[k] !== 1'b1 || acc_addr[k] !== 8'(124 + k) ||
            acc_dat[k] !== exp_d[k]) begin
          bad++; $display("FAIL wr31_beat%0d: w=%b addr=%0d data=%h want 1 %0d %h",
                          k, acc_w[k], acc_addr[k], acc_dat[k], 124 + k, exp_d[k]);
        end
      end
    end
    do_access(1'b0, 6'd31, 32'h0);
    total++;
    if (dbg_rdata !== 32'h12345678 || ack_cyc != 7) begin
      bad++; $display("FAIL rd31: data=%h cyc=%0d want 12345678 7",
                      dbg_rdata, ack_cyc);
    end
  endtask

  task automatic test_x0_range();
    do_access(1'b1, 6'd0, 32'hFFFFFFFF);
    total++;
    if (ack_cyc != 2 || ack_err !== 1'b0 || n_acc != 0) begin
      bad++; $display("FAIL wr0: cyc=%0d err=%b nacc=%0d want 2 0 0",
                      ack_cyc, ack_err, n_acc);
    end
    do_access(1'b0, 6'd0, 32'h0);
    total++;
    if (dbg_rdata !== 32'h0 || ack_cyc != 2 || ack_err !== 1'b0) begin
      bad++; $display("FAIL rd0: data=%h cyc=%0d err=%b want 0 2 0",
                      dbg_rdata, ack_cyc, ack_err);
    end
    do_access(1'b0, 6'd40, 32'h0);
    total++;
    if (ack_cyc != 2 || ack_err !== 1'b1 || n_acc != 0) begin
      bad++; $display("FAIL rd40: cyc=%0d err=%b nacc=%0d want 2 1 0",
                      ack_cyc, ack_err, n_acc);
    end
  endtask

  task automatic test_not_halted();
    halted = 1'b0;
    cpu_wen = 1'b1; cpu_waddr = 8'd50; cpu_wdata = 8'h5A;
    do_access(1'b0, 6'd5, 32'h0);
    cpu_wen = 1'b0; halted = 1'b1;
    total++;
    if (ack_cyc != 2 || ack_err !== 1'b1) begin
      bad++; $display("FAIL nohalt_ack: cyc=%0d err=%b want 2 1", ack_cyc, ack_err);
    end
    total++;
    if (n_acc < 1 || acc_w[0] !== 1'b1 || acc_addr[0] !== 8'd50 ||
        acc_dat[0] !== 8'h5A) begin
      bad++; $display("FAIL nohalt_cpu: nacc=%0d addr=%0d data=%h want >=1 50 5a",
                      n_acc, acc_addr[0], acc_dat[0]);
    end
  endtask

  task automatic test_contention();
    cpu_write(8'd200, 8'hEE);
    cr_from = 3; cr_to = 4;
    do_access(1'b0, 6'd5, 32'h0);
    cr_from = 0; cr_to = -1;
    total++;
    if (ack_cyc != 9) begin
      bad++; $display("FAIL cont_ack: cyc=%0d want 9", ack_cyc);
    end
    total++;
    if (dbg_rdata !== 32'hA1B2C3D4) begin
      bad++; $display("FAIL cont_data: got %h want a1b2c3d4", dbg_rdata);
    end
    total++;
    if (n_acc != 6 || acc_addr[1] !== 8'd200 || acc_addr[2] !== 8'd200 ||
        acc_cyc[1] != 3 || acc_addr[3] !== 8'd21 || acc_cyc[3] != 5) begin
      bad++; $display("FAIL cont_port: nacc=%0d a1=%0d a2=%0d c1=%0d a3=%0d c3=%0d",
                      n_acc, acc_addr[1], acc_addr[2], acc_cyc[1],
                      acc_addr[3], acc_cyc[3]);
    end
  endtask

  task automatic test_reset_mid();
    cyc = 0;
    dbg_we = 1'b0; dbg_regno = 6'd5; dbg_req = 1'b1;
    while (cyc < 3) begin
      @(posedge clk); cyc++;
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({dbg_ack, dbg_busy, dbg_err, ram_ren, ram_wen} !== 5'b00000) begin
      bad++; $display("FAIL rstmid_flags: ack/busy/err/ren/wen=%b want 00000",
                      {dbg_ack, dbg_busy, dbg_err, ram_ren, ram_wen});
    end
    total++;
    if (dbg_rdata !== 32'h0) begin
      bad++; $display("FAIL rstmid_rdata: got %h want 0", dbg_rdata);
    end
    dbg_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #2;
    total++;
    if (dbg_busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_idle: busy=%b want 0", dbg_busy);
    end
  endtask

  task automatic test_abort();
    halt_drop = 4;
    do_access(1'b1, 6'd7, 32'h11223344);
    halt_drop = 0; halted = 1'b1;
    total++;
    if (ack_cyc != 5 || ack_err !== 1'b1) begin
      bad++; $display("FAIL abort_ack: cyc=%0d err=%b want 5 1", ack_cyc, ack_err);
    end
    total++;
    if (n_acc != 2 || acc_addr[0] !== 8'd28 || acc_dat[0] !== 8'h44 ||
        acc_addr[1] !== 8'd29 || acc_dat[1] !== 8'h33) begin
      bad++; $display("FAIL abort_wen: nacc=%0d a0=%0d d0=%h a1=%0d d1=%h want 2 28 44 29 33",
                      n_acc, acc_addr[0], acc_dat[0], acc_addr[1], acc_dat[1]);
    end
  endtask

  initial begin
    cpu_waddr = 0; cpu_wdata = 0; cpu_raddr = 0;
    cpu_wen = 0; cpu_ren = 0; halted = 1'b1;
    dbg_req = 0; dbg_we = 0; dbg_regno = 0; dbg_wdata = 0;
    test_reset();
    test_read_x5();
    test_write_x31();
    test_x0_range();
    test_not_halted();
    test_contention();
    test_reset_mid();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
